// File: rtl/writeback_stage.sv
// Writeback stage: buffers execution results in a 2-entry FIFO and presents the
// head entry to the register file, updating carry feedback and zero flags on retire.
module writeback_stage #(
    parameter int BITS_ARRAY = 64,
    parameter int BITS_DATA  = 8,
    parameter int BITS_ADDR  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [BITS_ARRAY-1:0] executionResult,
    input  logic [BITS_DATA-1:0]  carryTotal,
    input  logic [BITS_ADDR-1:0]  destAddr,
    input  logic                  writeReg,
    input  logic                  updateCarry,
    input  logic                  carryClear,
    output logic                  regWriteEnable,
    output logic [BITS_ADDR-1:0]  regWriteAddr,
    output logic [BITS_ARRAY-1:0] regWriteData,
    input  logic                  regWriteReady,
    output logic [BITS_DATA-1:0]  auxCarry,
    output logic [BITS_DATA-1:0]  zeroFlags,
    output logic                  busy
);

    localparam int LANES = BITS_DATA;

    typedef struct packed {
        logic [BITS_ARRAY-1:0] result;
        logic [BITS_DATA-1:0]  carry;
        logic [BITS_ADDR-1:0]  addr;
        logic                  write_reg;
        logic                  update_carry;
    } entry_t;

    entry_t         mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;
    entry_t         head;
    logic           push;
    logic           pop;
    logic [LANES-1:0] carry_rev;
    logic [LANES-1:0] lane_zero;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the opposite side's ready in the same cycle.
    assign head    = mem[rd_ptr];
    assign inReady = (count < 2'd2);
    assign push    = inValid && inReady;
    assign pop     = (count != 2'd0) && (regWriteReady || !head.write_reg);

    assign regWriteEnable = (count != 2'd0) && head.write_reg;
    assign regWriteAddr   = head.addr;
    assign regWriteData   = head.result;
    assign busy           = (count != 2'd0);

    // Carries come back to execution bit-reversed: lane i lands on bit LANES-1-i.
    always_comb begin
        carry_rev = '0;
        lane_zero = '0;
        for (int i = 0; i < LANES; i++) begin
            carry_rev[LANES-1-i] = head.carry[i];
            lane_zero[i]         = (head.result[i*BITS_DATA +: BITS_DATA] == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{result:       executionResult,
                                 carry:        carryTotal,
                                 addr:         destAddr,
                                 write_reg:    writeReg,
                                 update_carry: updateCarry};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // A clear wins over a carry update retiring on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auxCarry  <= '0;
            zeroFlags <= '0;
        end else begin
            if (carryClear) begin
                auxCarry <= '0;
            end else if (pop && head.update_carry) begin
                auxCarry <= carry_rev;
            end
            if (pop) begin
                zeroFlags <= lane_zero;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [63:0] executionResult;
    logic [7:0]  carryTotal;
    logic [3:0]  destAddr;
    logic        writeReg;
    logic        updateCarry;
    logic        carryClear;
    logic        regWriteEnable;
    logic [3:0]  regWriteAddr;
    logic [63:0] regWriteData;
    logic        regWriteReady;
    logic [7:0]  auxCarry;
    logic [7:0]  zeroFlags;
    logic        busy;

    writeback_stage dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .executionResult(executionResult), .carryTotal(carryTotal),
        .destAddr(destAddr), .writeReg(writeReg), .updateCarry(updateCarry),
        .carryClear(carryClear), .regWriteEnable(regWriteEnable),
        .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
        .regWriteReady(regWriteReady), .auxCarry(auxCarry),
        .zeroFlags(zeroFlags), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [7:0]  carry;
        logic [3:0]  addr;
        logic        wr;
        logic        uc;
    } ent_t;

    ent_t        mq[$];
    logic [67:0] exp_q[$];
    logic [7:0]  m_aux;
    logic [7:0]  m_zf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_aux = 8'h00;
        m_zf  = 8'h00;
    endtask

    task automatic set_in(input logic v, input logic [63:0] r, input logic [7:0] c,
                          input logic [3:0] a, input logic w, input logic u,
                          input logic clr, input logic rr);
        inValid = v; executionResult = r; carryTotal = c; destAddr = a;
        writeReg = w; updateCarry = u; carryClear = clr; regWriteReady = rr;
    endtask

    // Reference model advances from the spec rules, then the clock edge.
    task automatic tick();
        ent_t h;
        ent_t n;
        bit   do_push;
        bit   do_pop;
        do_push = inValid && (mq.size() < 2);
        do_pop  = (mq.size() > 0) && (regWriteReady || !mq[0].wr);
        if (do_pop) begin
            h = mq.pop_front();
            for (int i = 0; i < 8; i++) begin
                m_zf[i] = (((h.res >> (8 * i)) & 64'hFF) == 64'h0);
                if (h.uc) m_aux[7 - i] = h.carry[i];
            end
        end
        if (carryClear) m_aux = 8'h00;
        if (do_push) begin
            n.res = executionResult; n.carry = carryTotal; n.addr = destAddr;
            n.wr = writeReg; n.uc = updateCarry;
            mq.push_back(n);
            if (writeReg) exp_q.push_back({destAddr, executionResult});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        set_in(1'b0, 64'h0, 8'h0, 4'h0, 1'b0, 1'b0, 1'b0, rr);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(1'b1);
        model_reset();
        #12;
        n_checks++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready got %b want 1", inReady); end
        n_checks++; if (regWriteEnable !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", regWriteEnable); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (auxCarry !== 8'h00 || zeroFlags !== 8'h00) begin n_fail++; $display("FAIL reset_flags got aux %h zf %h want 00 00", auxCarry, zeroFlags); end
        n_checks++; if (regWriteAddr !== 4'h0 || regWriteData !== 64'h0) begin n_fail++; $display("FAIL reset_outs got %h %h want 0 0", regWriteAddr, regWriteData); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        set_in(1'b1, 64'h0102030405060708, 8'h00, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        n_checks++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 4'd3 || regWriteData !== 64'h0102030405060708) begin
            n_fail++; $display("FAIL single_write got en %b addr %h data %h want 1 3 0102030405060708", regWriteEnable, regWriteAddr, regWriteData);
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy1 got %b want 1", busy); end
        tick();
        n_checks++; if (busy !== 1'b0 || regWriteEnable !== 1'b0) begin n_fail++; $display("FAIL single_busy0 got busy %b en %b want 0 0", busy, regWriteEnable); end
        n_checks++; if (zeroFlags !== 8'h00) begin n_fail++; $display("FAIL single_zf got %h want 00", zeroFlags); end
    endtask

    task automatic test_carry_map();
        logic [7:0] cin [2];
        logic [7:0] cexp [2];
        cin[0] = 8'h01; cexp[0] = 8'h80;
        cin[1] = 8'hF0; cexp[1] = 8'h0F;
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, 64'h1111111111111111, cin[k], 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
            idle(1'b1);
            tick();
            n_checks++; if (auxCarry !== cexp[k]) begin n_fail++; $display("FAIL carry_map%0d got %h want %h", k, auxCarry, cexp[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d [3];
        d[0] = 64'hAAAA0000AAAA0001; d[1] = 64'hBBBB0000BBBB0002; d[2] = 64'hCCCC0000CCCC0003;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                n_checks++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL bp_full got inReady %b want 0", inReady); end
            end
            set_in(1'b1, d[k], 8'h00, 4'(k + 8), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 4'd8 || regWriteData !== d[0]) begin
                n_fail++; $display("FAIL bp_hold%0d got en %b addr %h data %h want 1 8 %h", k, regWriteEnable, regWriteAddr, regWriteData, d[0]);
            end
            tick();
        end
        idle(1'b1);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (regWriteEnable !== 1'b1 || regWriteAddr !== 4'(k + 8) || regWriteData !== d[k]) begin
                n_fail++; $display("FAIL bp_order%0d got en %b addr %h data %h want 1 %h %h", k, regWriteEnable, regWriteAddr, regWriteData, k + 8, d[k]);
            end
            tick();
        end
        n_checks++; if (inReady !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain got inReady %b busy %b want 1 0", inReady, busy); end
    endtask

    task automatic test_no_write();
        set_in(1'b1, 64'h0101010101010101, 8'hFF, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        n_checks++; if (regWriteEnable !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL nowrite_en got en %b busy %b want 0 1", regWriteEnable, busy); end
        tick();
        n_checks++; if (auxCarry !== 8'hFF || busy !== 1'b0) begin n_fail++; $display("FAIL nowrite_pop got aux %h busy %b want ff 0", auxCarry, busy); end
    endtask

    task automatic test_conflict_zero();
        set_in(1'b1, 64'h00FF00FF00FF00FF, 8'h01, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        carryClear = 1'b1;
        tick();
        carryClear = 1'b0;
        n_checks++; if (auxCarry !== 8'h00) begin n_fail++; $display("FAIL conflict_aux got %h want 00", auxCarry); end
        n_checks++; if (zeroFlags !== 8'hAA) begin n_fail++; $display("FAIL zero_flags got %h want aa", zeroFlags); end
    endtask

    task automatic test_reset_mid_stall();
        set_in(1'b1, 64'h1234, 8'h0F, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 64'h5678, 8'h0F, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle(1'b0);
        n_checks++; if (inReady !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_full got inReady %b busy %b want 0 1", inReady, busy); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++; if (inReady !== 1'b1 || busy !== 1'b0 || regWriteEnable !== 1'b0 || regWriteData !== 64'h0 || regWriteAddr !== 4'h0) begin
            n_fail++; $display("FAIL stall_reset got inReady %b busy %b en %b addr %h data %h want 1 0 0 0 0", inReady, busy, regWriteEnable, regWriteAddr, regWriteData);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        idle(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (regWriteEnable !== 1'b0) begin n_fail++; $display("FAIL stall_nowrite%0d got %b want 0", k, regWriteEnable); end
        end
        set_in(1'b1, 64'h9ABC, 8'h00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle(1'b1);
        n_checks++; if (regWriteEnable !== 1'b1 || regWriteData !== 64'h9ABC) begin n_fail++; $display("FAIL first_push got en %b data %h want 1 9abc", regWriteEnable, regWriteData); end
        tick();
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [67:0] got;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            set_in(1'($urandom_range(0, 1)), r, 8'($urandom), 4'($urandom),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            n_checks++; if (inReady !== (mq.size() < 2) || busy !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL rand_status c%0d got inReady %b busy %b want depth %0d", c, inReady, busy, mq.size());
            end
            n_checks++; if (regWriteEnable !== ((mq.size() > 0) && mq[0].wr)) begin
                n_fail++; $display("FAIL rand_en c%0d got %b", c, regWriteEnable);
            end
            n_checks++; if (auxCarry !== m_aux || zeroFlags !== m_zf) begin
                n_fail++; $display("FAIL rand_flags c%0d got aux %h zf %h want %h %h", c, auxCarry, zeroFlags, m_aux, m_zf);
            end
            if (regWriteEnable === 1'b1 && regWriteReady === 1'b1) begin
                got = {regWriteAddr, regWriteData};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_write c%0d got %h want none", c, got);
                end else if (got !== exp_q[0]) begin
                    n_fail++; $display("FAIL rand_write c%0d got %h want %h", c, got, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_carry_map();
        test_backpressure();
        test_no_write();
        test_conflict_zero();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameters SHALL be: BITS_ARRAY, default 64, result width; BITS_DATA, default 8, lane width and lane count; BITS_ADDR, default 4, register address width.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 inValid  input  1  execution result valid.
REQ-006 inReady  output  1  stage can accept a result.
REQ-007 executionResult  input  BITS_ARRAY  eight 8-bit lane results, lane 0 in [7:0].
REQ-008 carryTotal  input  BITS_DATA  lane carries, bit i = lane i.
REQ-009 destAddr  input  BITS_ADDR  destination register.
REQ-010 writeReg  input  1  result is written to the register file.
REQ-011 updateCarry  input  1  carries update the carry register.
REQ-012 carryClear  input  1  synchronous clear of the carry register.
REQ-013 regWriteEnable  output  1  register-file write request.
REQ-014 regWriteAddr  output  BITS_ADDR  write address.
REQ-015 regWriteData  output  BITS_ARRAY  write data.
REQ-016 regWriteReady  input  1  register file accepts the write this cycle.
REQ-017 auxCarry  output  BITS_DATA  carry feedback to execution; lane i carry on bit (7-i).
REQ-018 zeroFlags  output  BITS_DATA  bit i set when the last retired lane i result was zero.
REQ-019 busy  output  1  one or more entries are buffered.

Function
REQ-020 Storage SHALL be a 2-entry FIFO holding {executionResult, carryTotal, destAddr, writeReg, updateCarry}, with a 2-bit count of 0..2.
REQ-021 inReady SHALL equal (count < 2), registered-state only, with no combinational path from regWriteReady.
REQ-022 A push SHALL occur when inValid && inReady; when inValid is low, inputs SHALL be ignored.
REQ-023 The head entry SHALL drive regWriteAddr and regWriteData; regWriteEnable SHALL equal (count > 0) && head.writeReg.
REQ-024 The head SHALL retire (pop) when count > 0 and either regWriteReady is high or head.writeReg is low.
REQ-025 Latency SHALL be: a result accepted at edge N is presented on regWriteEnable/Data from cycle N+1 at the earliest; there is no bypass.
REQ-026 A push and a pop in the same cycle SHALL leave count unchanged and preserve order; this applies only at count = 1, since count = 2 blocks the push.
REQ-027 While regWriteReady is low, regWriteAddr, regWriteData and regWriteEnable SHALL hold stable.
REQ-028 On a pop with head.updateCarry set, auxCarry[7-i] SHALL load head.carryTotal[i] for i = 0..7.
REQ-029 On every pop, zeroFlags[i] SHALL load (head.executionResult lane i == 0).
REQ-030 carryClear SHALL zero auxCarry on the next edge and SHALL take priority over a simultaneous carry update.
REQ-031 busy SHALL equal (count != 0).
REQ-032 Read and write pointers SHALL be 1 bit wide and SHALL wrap 1 -> 0.

Reset
REQ-033 Reset assertion SHALL immediately force count = 0, both pointers = 0, inReady = 1, regWriteEnable = 0, busy = 0, auxCarry = 0x00, zeroFlags = 0x00, and regWriteAddr/regWriteData = 0.
REQ-034 Reset mid-operation SHALL discard buffered entries without generating a write.
REQ-035 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-036 Single write: result 0x0102030405060708, destAddr 3, writeReg=1, regWriteReady=1 -> regWriteEnable=1, addr 3, data 0x0102030405060708 in the next cycle; busy drops one cycle later.
REQ-037 Carry mapping: carryTotal 0x01 with updateCarry=1 -> auxCarry 0x80 after retire; carryTotal 0xF0 -> auxCarry 0x0F.
REQ-038 Backpressure: regWriteReady=0, push three results -> first two accepted, inReady=0, outputs held; release -> writes in push order, then inReady=1.
REQ-039 No-write entry: writeReg=0, updateCarry=1, carryTotal 0xFF -> no regWriteEnable, auxCarry 0xFF, pop regardless of regWriteReady.
REQ-040 Conflict and zero flags: carryClear asserted on the same edge as an updateCarry pop -> auxCarry 0x00; result 0x00FF00FF00FF00FF -> zeroFlags 0xAA.
REQ-041 Reset with count=2 mid-stall -> outputs at reset values immediately, no write issued after release.
